// File: rtl/apu_issue_tracker_pkg.sv
// apu_issue_tracker_pkg: shared widths, tag and request types for the APU issue/return tracker
package apu_issue_tracker_pkg;
    localparam int NARGS = 3;
    localparam int WOP = 6;
    localparam int NDSFLAGS = 15;
    localparam int NUSFLAGS = 5;
    localparam int RAW = 6;
    localparam int APU_TRACK_DEPTH = 4;
    typedef logic [RAW-1:0] apu_tag_t;
    typedef struct packed {
        logic [WOP-1:0] op;
        logic [NARGS*32-1:0] operands;
        logic [NDSFLAGS-1:0] flags;
    } apu_req_t;
endpackage

// File: rtl/apu_issue_tracker_tag_fifo.sv
// apu_tag_fifo: in-order destination-tag FIFO exposing every entry and its valid bit for hazard checks
module apu_tag_fifo
    import apu_issue_tracker_pkg::*;
#(
    parameter int DEPTH = APU_TRACK_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  apu_tag_t                   push_tag,
    input  logic                       pop,
    output apu_tag_t                   head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     cnt,
    output apu_tag_t [DEPTH-1:0]       entries,
    output logic [DEPTH-1:0]           valid
);
    localparam int PW = $clog2(DEPTH);
    logic [PW-1:0] rd_ptr, wr_ptr;
    apu_tag_t mem [DEPTH];
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt <= '0;
        end else begin
            wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
            cnt <= cnt + (PW+1)'(push) - (PW+1)'(pop);
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_tag;
    end
    // An op granted and returned in the same cycle while empty reads straight from the push side
    assign head = empty ? push_tag : mem[rd_ptr];
    assign full = cnt == (PW+1)'(DEPTH);
    assign empty = cnt == '0;
    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        assign entries[i] = mem[i];
        assign valid[i] = {1'b0, PW'(i) - rd_ptr} < cnt;
    end
endmodule

// File: rtl/apu_issue_tracker.sv
// apu_issue_tracker: registers EX ops onto the APU req/gnt port, tracks in-flight destinations, routes results to writeback
module apu_issue_tracker
    import apu_issue_tracker_pkg::*;
#(
    parameter int DEPTH = APU_TRACK_DEPTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ex_valid_i,
    output logic                    ex_ready_o,
    input  logic [WOP-1:0]          ex_op_i,
    input  logic [NARGS*32-1:0]     ex_operands_i,
    input  logic [NDSFLAGS-1:0]     ex_flags_i,
    input  logic [RAW-1:0]          ex_waddr_i,
    input  logic [NARGS*RAW-1:0]    ex_raddr_i,
    input  logic [NARGS-1:0]        ex_rvalid_i,
    output logic                    hz_stall_o,
    output logic                    apu_req_o,
    input  logic                    apu_gnt_i,
    output logic [WOP-1:0]          apu_op_o,
    output logic [NARGS*32-1:0]     apu_operands_o,
    output logic [NDSFLAGS-1:0]     apu_flags_o,
    input  logic                    apu_rvalid_i,
    input  logic [31:0]             apu_result_i,
    input  logic [NUSFLAGS-1:0]     apu_rflags_i,
    output logic                    wb_valid_o,
    output logic [RAW-1:0]          wb_waddr_o,
    output logic [31:0]             wb_result_o,
    output logic [NUSFLAGS-1:0]     wb_rflags_o,
    output logic                    busy_o,
    output logic                    err_o
);
    localparam int CW = $clog2(DEPTH) + 1;
    logic req_pend, push, pop, full, empty, hit, accept;
    apu_req_t req_q;
    apu_tag_t req_waddr, head;
    logic [CW-1:0] cnt;
    apu_tag_t [DEPTH-1:0] entries;
    logic [DEPTH-1:0] valid;
    logic [(NARGS+1)*RAW-1:0] srcs;
    logic [NARGS:0] src_en;

    apu_tag_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk(clk), .rst(rst), .push(push), .push_tag(req_waddr), .pop(pop), .head(head),
        .full(full), .empty(empty), .cnt(cnt), .entries(entries), .valid(valid)
    );

    // Destination is checked too (WAW); sources only where the register is actually read
    assign srcs = {ex_waddr_i, ex_raddr_i};
    assign src_en = {1'b1, ex_rvalid_i};
    always_comb begin
        hit = 1'b0;
        for (int k = 0; k <= NARGS; k++) begin
            for (int e = 0; e < DEPTH; e++)
                hit = hit | (src_en[k] && srcs[k*RAW +: RAW] != '0 && valid[e] && srcs[k*RAW +: RAW] == entries[e]);
            hit = hit | (src_en[k] && srcs[k*RAW +: RAW] != '0 && req_pend && srcs[k*RAW +: RAW] == req_waddr);
        end
    end
    assign hz_stall_o = ex_valid_i && hit;
    // Room exists when in-flight plus pending stays below DEPTH; same-cycle pops are not credited
    assign ex_ready_o = (!req_pend || apu_gnt_i) && !full && !(req_pend && cnt == CW'(DEPTH-1)) && !hz_stall_o;
    assign accept = ex_valid_i && ex_ready_o;
    assign push = req_pend && apu_gnt_i;
    assign pop = apu_rvalid_i && (!empty || push);

    always_ff @(posedge clk) begin
        if (rst) begin
            req_pend <= 1'b0;
            req_q <= '0;
            req_waddr <= '0;
        end else begin
            req_pend <= accept || (req_pend && !apu_gnt_i);
            if (accept) begin
                req_q <= '{op: ex_op_i, operands: ex_operands_i, flags: ex_flags_i};
                req_waddr <= ex_waddr_i;
            end
        end
    end
    assign apu_req_o = req_pend;
    assign apu_op_o = req_q.op;
    assign apu_operands_o = req_q.operands;
    assign apu_flags_o = req_q.flags;

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid_o <= 1'b0;
            wb_waddr_o <= '0;
            wb_result_o <= '0;
            wb_rflags_o <= '0;
            err_o <= 1'b0;
        end else begin
            wb_valid_o <= pop;
            if (pop) begin
                wb_waddr_o <= head;
                wb_result_o <= apu_result_i;
                wb_rflags_o <= apu_rflags_i;
            end
            err_o <= err_o | (apu_rvalid_i && !pop);
        end
    end
    assign busy_o = req_pend || !empty;
endmodule

// File: tb/tb_apu_issue_tracker.sv
// tb_apu_issue_tracker: directed, table-driven and randomized checks against a queue-based reference model
module tb_apu_issue_tracker;
    import apu_issue_tracker_pkg::*;
    localparam int D = APU_TRACK_DEPTH;

    logic clk = 1'b0, rst;
    always #5 clk = ~clk;
    logic ex_valid_i, ex_ready_o, hz_stall_o, apu_req_o, apu_gnt_i, apu_rvalid_i;
    logic wb_valid_o, busy_o, err_o;
    logic [WOP-1:0] ex_op_i, apu_op_o;
    logic [NARGS*32-1:0] ex_operands_i, apu_operands_o;
    logic [NDSFLAGS-1:0] ex_flags_i, apu_flags_o;
    logic [RAW-1:0] ex_waddr_i, wb_waddr_o;
    logic [NARGS*RAW-1:0] ex_raddr_i;
    logic [NARGS-1:0] ex_rvalid_i;
    logic [31:0] apu_result_i, wb_result_o;
    logic [NUSFLAGS-1:0] apu_rflags_i, wb_rflags_o;

    apu_issue_tracker dut (
        .clk(clk), .rst(rst), .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o), .ex_op_i(ex_op_i),
        .ex_operands_i(ex_operands_i), .ex_flags_i(ex_flags_i), .ex_waddr_i(ex_waddr_i),
        .ex_raddr_i(ex_raddr_i), .ex_rvalid_i(ex_rvalid_i), .hz_stall_o(hz_stall_o),
        .apu_req_o(apu_req_o), .apu_gnt_i(apu_gnt_i), .apu_op_o(apu_op_o),
        .apu_operands_o(apu_operands_o), .apu_flags_o(apu_flags_o), .apu_rvalid_i(apu_rvalid_i),
        .apu_result_i(apu_result_i), .apu_rflags_i(apu_rflags_i), .wb_valid_o(wb_valid_o),
        .wb_waddr_o(wb_waddr_o), .wb_result_o(wb_result_o), .wb_rflags_o(wb_rflags_o),
        .busy_o(busy_o), .err_o(err_o)
    );

    // Reference model: in-flight tags as a queue, one pending request, writeback as plain variables
    apu_tag_t q[$];
    logic m_pend = 0, m_err = 0, m_wbv = 0;
    logic [WOP-1:0] m_op = 0;
    logic [NARGS*32-1:0] m_opnd = 0;
    logic [NDSFLAGS-1:0] m_flg = 0;
    apu_tag_t m_wa = 0, m_wbw = 0;
    logic [31:0] m_wbr = 0;
    logic [NUSFLAGS-1:0] m_wbf = 0;
    int n_cmp = 0, n_bad = 0, dut_grants = 0;

    typedef struct {
        apu_tag_t tag;
        apu_tag_t waddr;
        logic [NARGS*RAW-1:0] raddr;
        logic [NARGS-1:0] rv;
        logic hz;
    } hz_vec_t;
    hz_vec_t tbl[7];

    task automatic chk(input string n, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    function automatic logic in_flight(apu_tag_t a);
        if (a == 0) return 1'b0;
        foreach (q[i]) if (q[i] == a) return 1'b1;
        return m_pend && a == m_wa;
    endfunction

    function automatic logic exp_hz();
        logic h = in_flight(ex_waddr_i);
        for (int k = 0; k < NARGS; k++)
            if (ex_rvalid_i[k] && in_flight(ex_raddr_i[k*RAW +: RAW])) h = 1'b1;
        return ex_valid_i && h;
    endfunction

    task automatic tick();
        logic hz, rdy, push;
        #1;
        hz = exp_hz();
        rdy = (!m_pend || apu_gnt_i) && (q.size() + int'(m_pend) < D) && !hz;
        chk("hz_stall", hz_stall_o, hz);
        chk("ex_ready", ex_ready_o, rdy);
        chk("apu_req", apu_req_o, m_pend);
        chk("apu_op", apu_op_o, m_op);
        chk("apu_operands", apu_operands_o, m_opnd);
        chk("apu_flags", apu_flags_o, m_flg);
        chk("busy", busy_o, m_pend || q.size() != 0);
        chk("err", err_o, m_err);
        chk("wb_valid", wb_valid_o, m_wbv);
        chk("wb_waddr", wb_waddr_o, m_wbw);
        chk("wb_result", wb_result_o, m_wbr);
        chk("wb_rflags", wb_rflags_o, m_wbf);
        if (apu_req_o && apu_gnt_i && !rst) dut_grants++;
        if (rst) begin
            q.delete();
            {m_pend, m_err, m_wbv, m_op, m_opnd, m_flg, m_wa, m_wbw, m_wbr, m_wbf} = '0;
        end else begin
            push = m_pend && apu_gnt_i;
            if (push) q.push_back(m_wa);
            m_wbv = 1'b0;
            if (apu_rvalid_i) begin
                if (q.size() > 0) begin
                    m_wbv = 1'b1;
                    m_wbw = q.pop_front();
                    m_wbr = apu_result_i;
                    m_wbf = apu_rflags_i;
                end else m_err = 1'b1;
            end
            if (ex_valid_i && rdy) begin
                m_pend = 1'b1;
                m_op = ex_op_i;
                m_opnd = ex_operands_i;
                m_flg = ex_flags_i;
                m_wa = ex_waddr_i;
            end else if (push) m_pend = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ex_valid_i = 0;
        apu_gnt_i = 0;
        apu_rvalid_i = 0;
        ex_rvalid_i = 0;
        ex_raddr_i = 0;
    endtask

    task automatic set_op(input apu_tag_t w, input int s);
        ex_valid_i = 1;
        ex_waddr_i = w;
        ex_op_i = WOP'(w + s);
        ex_operands_i = {32'(s), 32'(w), $urandom};
        ex_flags_i = NDSFLAGS'($urandom);
        ex_raddr_i = 0;
        ex_rvalid_i = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        idle();
        tick();
        rst = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [NARGS*32-1:0] sv_opnd;
        logic [WOP-1:0] sv_op;
        tbl[0] = '{6'd7, 6'd1, {6'd0, 6'd7, 6'd0}, 3'b010, 1'b1};
        tbl[1] = '{6'd7, 6'd1, {6'd0, 6'd7, 6'd0}, 3'b000, 1'b0};
        tbl[2] = '{6'd7, 6'd7, 18'd0, 3'b000, 1'b1};
        tbl[3] = '{6'd0, 6'd0, 18'd0, 3'b111, 1'b0};
        tbl[4] = '{6'd7, 6'd2, {6'd5, 6'd4, 6'd3}, 3'b111, 1'b0};
        tbl[5] = '{6'd9, 6'd1, {6'd9, 6'd0, 6'd0}, 3'b100, 1'b1};
        tbl[6] = '{6'd9, 6'd0, {6'd0, 6'd0, 6'd9}, 3'b001, 1'b1};
        rst = 1;
        idle();
        ex_waddr_i = 0; ex_op_i = 0; ex_operands_i = 0; ex_flags_i = 0;
        apu_result_i = 0; apu_rflags_i = 0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        chk("rst_ready", ex_ready_o, 1);
        chk("rst_busy", busy_o, 0);
        chk("rst_req", apu_req_o, 0);
        chk("rst_wbv", wb_valid_o, 0);
        chk("rst_err", err_o, 0);

        // single op, gnt with req, rvalid three cycles after grant
        set_op(5, 1); tick();
        idle(); apu_gnt_i = 1;
        chk("t1_req", apu_req_o, 1);
        tick();
        idle(); tick(); tick();
        apu_rvalid_i = 1; apu_result_i = 32'hDEADBEEF; apu_rflags_i = 5'h3;
        chk("t1_busy_rv", busy_o, 1);
        tick();
        idle();
        chk("t1_wbv", wb_valid_o, 1);
        chk("t1_wbw", wb_waddr_o, 5);
        chk("t1_wbr", wb_result_o, 32'hDEADBEEF);
        chk("t1_busy_after", busy_o, 0);
        tick();
        chk("t1_pulse", wb_valid_o, 0);

        // grant withheld four cycles
        set_op(9, 2); sv_opnd = ex_operands_i; sv_op = ex_op_i; tick();
        set_op(10, 3);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t2_req", apu_req_o, 1);
            chk("t2_opnd_stable", apu_operands_o, sv_opnd);
            chk("t2_op_stable", apu_op_o, sv_op);
            chk("t2_ready", ex_ready_o, 0);
            tick();
        end
        apu_gnt_i = 1;
        #1;
        chk("t2_ready_gnt", ex_ready_o, 1);
        tick();
        idle(); apu_gnt_i = 1; tick();
        idle(); apu_rvalid_i = 1; tick(); tick();
        idle(); tick();

        // fill to DEPTH with grant tied high
        do_reset();
        dut_grants = 0;
        for (int w = 1; w <= 4; w++) begin
            set_op(6'(w), w); apu_gnt_i = 1; tick();
        end
        set_op(5, 5); apu_gnt_i = 1;
        repeat (4) tick();
        chk("t3_grants", dut_grants, 4);
        #1;
        chk("t3_ready_full", ex_ready_o, 0);
        idle(); apu_gnt_i = 1;
        for (int k = 1; k <= 4; k++) begin
            apu_rvalid_i = 1; apu_result_i = 32'(k * 100); tick();
            chk("t3_wb_order", wb_waddr_o, k);
            chk("t3_wb_res", wb_result_o, k * 100);
        end
        idle();
        set_op(5, 5); apu_gnt_i = 1; tick();
        set_op(6, 6); apu_gnt_i = 1; tick();
        idle(); apu_gnt_i = 1; tick();
        chk("t3_grants6", dut_grants, 6);
        idle(); apu_rvalid_i = 1; tick();
        chk("t3_wb5", wb_waddr_o, 5);
        tick();
        chk("t3_wb6", wb_waddr_o, 6);
        idle(); tick();

        // simultaneous grant and return at cnt==DEPTH-1, then at cnt==0
        do_reset();
        for (int w = 1; w <= 4; w++) begin
            set_op(6'(w), w); apu_gnt_i = 1; tick();
        end
        idle(); apu_gnt_i = 1; apu_rvalid_i = 1; tick();
        chk("t4_wb1", wb_waddr_o, 1);
        idle();
        for (int k = 2; k <= 4; k++) begin
            apu_rvalid_i = 1; tick();
            chk("t4_order", wb_waddr_o, k);
        end
        idle(); tick();
        chk("t4_drained", busy_o, 0);
        set_op(11, 11); tick();
        idle(); apu_gnt_i = 1; apu_rvalid_i = 1; tick();
        chk("t4_bypass_wbw", wb_waddr_o, 11);
        chk("t4_bypass_err", err_o, 0);
        idle(); tick();

        // hazard table
        foreach (tbl[i]) begin
            do_reset();
            set_op(tbl[i].tag, i); tick();
            idle(); apu_gnt_i = 1; tick();
            idle();
            ex_valid_i = 1; ex_waddr_i = tbl[i].waddr; ex_raddr_i = tbl[i].raddr; ex_rvalid_i = tbl[i].rv;
            #1;
            chk("t5_tbl_hz", hz_stall_o, tbl[i].hz);
            chk("t5_tbl_ready", ex_ready_o, !tbl[i].hz);
            tick();
        end

        // stall lasts until the writeback of 7
        do_reset();
        set_op(7, 7); tick();
        idle(); apu_gnt_i = 1; tick();
        idle(); ex_valid_i = 1; ex_waddr_i = 3; ex_raddr_i = {6'd0, 6'd7, 6'd0}; ex_rvalid_i = 3'b010;
        repeat (3) begin
            #1;
            chk("t5_stall", hz_stall_o, 1);
            chk("t5_stall_ready", ex_ready_o, 0);
            tick();
        end
        apu_rvalid_i = 1;
        #1;
        chk("t5_pop_cycle", hz_stall_o, 1);
        tick();
        apu_rvalid_i = 0;
        #1;
        chk("t5_released", hz_stall_o, 0);
        chk("t5_wb7", wb_waddr_o, 7);
        chk("t5_ready", ex_ready_o, 1);
        tick();
        idle(); apu_gnt_i = 1; tick();
        idle(); apu_rvalid_i = 1; tick();
        idle(); tick();

        // stray return and mid-flight reset
        do_reset();
        apu_rvalid_i = 1; tick();
        idle();
        chk("t6_err", err_o, 1);
        chk("t6_no_wb", wb_valid_o, 0);
        tick();
        chk("t6_sticky", err_o, 1);
        do_reset();
        for (int w = 1; w <= 3; w++) begin
            set_op(6'(w), w); apu_gnt_i = 1; tick();
        end
        idle(); apu_gnt_i = 1; tick();
        idle();
        chk("t6_busy", busy_o, 1);
        do_reset();
        chk("t6_rst_ready", ex_ready_o, 1);
        chk("t6_rst_busy", busy_o, 0);
        chk("t6_rst_req", apu_req_o, 0);
        apu_rvalid_i = 1; tick();
        idle();
        chk("t6_flushed", err_o, 1);

        // randomized traffic against the model
        do_reset();
        for (int c = 0; c < 800; c++) begin
            rst = ($urandom % 150) == 0;
            ex_valid_i = ($urandom % 10) < 7;
            ex_waddr_i = RAW'($urandom_range(0, 7));
            ex_raddr_i = {RAW'($urandom_range(0, 7)), RAW'($urandom_range(0, 7)), RAW'($urandom_range(0, 7))};
            ex_rvalid_i = NARGS'($urandom);
            ex_op_i = WOP'($urandom);
            ex_operands_i = {$urandom, $urandom, $urandom};
            ex_flags_i = NDSFLAGS'($urandom);
            apu_gnt_i = $urandom % 2;
            apu_rvalid_i = q.size() > 0 && ($urandom % 3) == 0;
            apu_result_i = $urandom;
            apu_rflags_i = NUSFLAGS'($urandom);
            tick();
        end
        rst = 0;
        idle();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
